// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, line levels
// and a counter-width helper reusable by a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam logic STOP_LEVEL    = 1'b1;

    // At least one bit, even for a modulus of 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-clks_per_bit baud counter; bit_tick_o marks the last cycle of a bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned clks_per_bit = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam int unsigned CNT_W = cnt_width(clks_per_bit);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(clks_per_bit - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign bit_tick_o = en_i && !clear_i && (cnt_q == TERMINAL);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame and shifts it out as
// start, data LSB first, optional even parity, stop. All outputs registered.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned width        = 8,
    parameter int unsigned clks_per_bit = 16,
    parameter bit          parity_en    = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [width-1:0] fifo_dout_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int unsigned IDX_W = cnt_width(width);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(width - 1);

    uart_state_e      state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [width-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic             baud_run;
    logic             bit_tick;

    assign baud_run = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);

    uart_baud_cnt #(
        .clks_per_bit(clks_per_bit)
    ) u_baud_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (!baud_run),
        .en_i      (baud_run),
        .bit_tick_o(bit_tick)
    );

    // NOTE: every variable gets its default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        unique case (state_q)
            IDLE: begin
                if (rd_en_q) state_d = FETCH;
            end
            FETCH: begin
                shift_d  = fifo_dout_i;
                parity_d = ^fifo_dout_i;
                state_d  = START;
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = parity_en ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered line and
    // strobe line up with the state they belong to; the pop strobe is raised
    // in the IDLE cycle that immediately precedes FETCH.
    always_comb begin
        rd_en_d = (state_d == IDLE) && enable_i && !fifo_empty_i;
        busy_d  = rd_en_d || (state_d != IDLE);
        tx_d    = TX_IDLE_LEVEL;
        unique case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = STOP_LEVEL;
            default: tx_d = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= TX_IDLE_LEVEL;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage directly downstream of fifo.
- Pops bytes from the fifo read port and shifts each out as an asynchronous serial frame on a single line: start bit, data LSB first, optional parity, one stop bit.
- Sits between the fifo and the device pin.
- Sole owner of the fifo read enable.

Parameters:
- width, 8: data bits per frame; must match the fifo width.
- clks_per_bit, 16: clk_i cycles per serial bit; minimum 2.
- parity_en, 0: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  1 permits starting new frames; a frame in progress always completes.
- fifo_dout_i  input  width  fifo read data; valid the cycle after fifo_rd_en_o is asserted.
- fifo_empty_i  input  1  fifo empty flag.
- fifo_rd_en_o  output  1  one-cycle pop strobe to the fifo.
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  1 from pop strobe through the final stop-bit cycle.

Behaviour:
- Single clock is clk_i. Reset is asynchronous and active-low on reset_i.
- Reset values: tx_o=1, fifo_rd_en_o=0, busy_o=0, state=IDLE, counters=0, shift register=0. All outputs are registered.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - enable_i=1 and fifo_empty_i=0: fifo_rd_en_o=1 for exactly this cycle, busy_o=1, go to FETCH.
  - Otherwise stay in IDLE with tx_o=1.
- FETCH (one cycle): capture fifo_dout_i into the shift register, compute parity as the XOR of the data bits, go to START.
- Latency: pop in cycle N; tx_o goes low from cycle N+2.
- START: tx_o=0 for clks_per_bit cycles.
- DATA:
  - Each of the width bits is driven for clks_per_bit cycles, LSB first.
  - Bit index counter runs 0..width-1.
  - Baud counter runs 0..clks_per_bit-1 and wraps to 0 on each bit boundary.
- PARITY: entered only when parity_en=1. tx_o=even parity bit for clks_per_bit cycles.
- STOP: tx_o=1 for clks_per_bit cycles, then IDLE.
- busy_o drops in the first IDLE cycle.
- Back-to-back frames: with data available, the IDLE cycle plus the FETCH cycle give exactly 2 extra high cycles between frames.
- fifo_rd_en_o is never asserted while fifo_empty_i=1, and never outside IDLE. This guarantees no underflow and at most one pop per frame.
- enable_i deasserted mid-frame: the current frame finishes intact; no new pop occurs.
- fifo_empty_i rising after the pop has no effect; the data is already committed.
- Reset mid-frame: tx_o returns high immediately (asynchronous). The byte is lost and is not re-popped.
- Counter widths: the baud counter is clog2(clks_per_bit) bits; the bit index is clog2(width) bits. Neither counter exceeds its terminal value.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (IDLE..STOP, 3-bit);
  - TX_IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- One sub-module, uart_baud_cnt:
  - modulo-clks_per_bit counter with clear input and a bit_tick output, asserted on the terminal count;
  - reusable by a future fifo_uart_rx.

Test Plan:
1. Reset: hold reset_i=0 for 19 time units with the fifo empty -> tx_o=1, busy_o=0, fifo_rd_en_o=0. Release: still idle while empty.
2. Single byte, clks_per_bit=4, parity_en=0: write 'hf0 -> one pop pulse, then tx_o low 2 cycles later. Line sequence, each value held 4 cycles: 0, 0,0,0,0,1,1,1,1, 1. busy_o falls after 40 cycles of frame.
3. Parity, parity_en=1: byte 'h07 -> parity bit 1. Byte 'h03 -> parity bit 0. Frame length is 11 bits.
4. Back-to-back, fifo preloaded with 'h55, 'haa, 'h00: exactly 3 pops and 3 frames in order, with exactly 2 high cycles between stop bit and next start bit. No pop is issued once empty.
5. enable_i=0 asserted mid-frame of 'h81 -> frame completes correctly. No further pop while the fifo still holds data. Re-enabling resumes with the next byte.
6. Reset asserted during DATA bit 3 -> tx_o=1 asynchronously. After release, the next fifo byte is sent with a clean frame.
